int_divider: RTL and testbench

INT_DIVIDER -- requirements
Module: int_divider

---
 rtl/int_divider.sv | 183 ++++++++++++++++++
 tb/tb_int_divider.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/int_divider.sv
// Fixed-latency restoring integer divider: WIDTH cycles of shift/subtract, then one FIX cycle.
// Define DIV_SIGNED_EN for two's-complement operands; the default build is unsigned.
module int_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
`ifdef DIV_SIGNED_EN
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction
`endif

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] diff_s;
  logic           ge_s;

  // Next-state, datapath and output computation.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    zero_d    = zero_q;
    q_d       = q_q;
    r_d       = r_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
`ifdef DIV_SIGNED_EN
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
`endif
    shifted_s = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    diff_s    = shifted_s - {1'b0, div_q};
    ge_s      = (shifted_s >= {1'b0, div_q});

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          dbz_d  = 1'b0;
          cnt_d  = '0;
          rem_d  = '0;
          zero_d = (y == '0);
`ifdef DIV_SIGNED_EN
          quo_d   = neg_if(x, x[WIDTH-1]);
          div_d   = neg_if(y, y[WIDTH-1]);
          neg_q_d = x[WIDTH-1] ^ y[WIDTH-1];
          neg_r_d = x[WIDTH-1];
`else
          quo_d   = x;
          div_d   = y;
`endif
          state_d = (y == '0) ? FIX : CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        // One restoring step; the extra remainder bit keeps the compare exact.
        if (ge_s) begin
          rem_d = diff_s;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted_s;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == LAST_STEP) begin
          state_d = FIX;
        end else begin
          state_d = CALC;
        end
      end
      FIX: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
        if (zero_q) begin
          // quo still holds the (magnitude of the) dividend, so r recovers x.
          q_d   = '1;
          dbz_d = 1'b1;
`ifdef DIV_SIGNED_EN
          r_d   = neg_if(quo_q, neg_r_q);
`else
          r_d   = quo_q;
`endif
        end else begin
          dbz_d = 1'b0;
`ifdef DIV_SIGNED_EN
          q_d   = neg_if(quo_q, neg_q_q);
          r_d   = neg_if(rem_q[WIDTH-1:0], neg_r_q);
`else
          q_d   = quo_q;
          r_d   = rem_q[WIDTH-1:0];
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
`endif
    end
  end

  assign q           = q_q;
  assign r           = r_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_int_divider.sv
// Directed-vector bench for int_divider: table of operands/results plus reset and back-to-back sequences.
module tb_int_divider;

  logic        clk;
  logic        rst;
  logic [15:0] x;
  logic [15:0] y;
  logic        start;
  logic [15:0] q;
  logic [15:0] r;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int n_tests;
  int n_fail;

  int_divider #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .start(start),
    .q(q), .r(r), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Start one division, perturb inputs while it runs, and report results and timing.
  task automatic run(input logic [15:0] a, input logic [15:0] b,
                     output logic [15:0] qo, output logic [15:0] ro, output logic dz,
                     output int lat, output int busy_n);
    logic got;
    @(negedge clk);
    x = a; y = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = ~a; y = b ^ 16'h5a5a;
    lat = 0; got = 1'b0;
    busy_n = busy ? 1 : 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) got = 1'b1;
      else if (busy) busy_n++;
      if (b != 16'h0000 && lat == 5) begin
        start = 1'b1; x = 16'h0001; y = 16'h0001;
      end
      if (lat == 6) start = 1'b0;
    end
    if (!got) lat = -1;
    qo = q; ro = r; dz = div_by_zero;
    @(posedge clk); #1;
    check("done_pulse_width", {31'd0, done}, 32'd0);
  endtask

  logic [15:0] qo, ro;
  logic        dz;
  int          lat, busy_n, gap;
  logic        got;

  initial begin
    n_tests = 0; n_fail = 0;
`ifdef DIV_SIGNED_EN
    vecs[0] = '{16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0};
    vecs[1] = '{16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0};
    vecs[2] = '{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0};
    vecs[3] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1};
    vecs[4] = '{16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0};
    vecs[5] = '{16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0};
    vecs[6] = '{16'h7FFF, 16'h0002, 16'h3FFF, 16'h0001, 1'b0};
    vecs[7] = '{16'h8000, 16'h0000, 16'hFFFF, 16'h8000, 1'b1};
`else
    vecs[0] = '{16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0};
    vecs[1] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0};
    vecs[3] = '{16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0};
    vecs[5] = '{16'h0005, 16'h000A, 16'h0000, 16'h0005, 1'b0};
    vecs[6] = '{16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0};
    vecs[7] = '{16'hFFFF, 16'h0100, 16'h00FF, 16'h00FF, 1'b0};
`endif

    x = 16'h0000; y = 16'h0000; start = 1'b0; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {12'd0, q, r, busy, done, div_by_zero, 1'b0}, 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run(vecs[i].x, vecs[i].y, qo, ro, dz, lat, busy_n);
      check($sformatf("vec%0d_q", i), {16'd0, qo}, {16'd0, vecs[i].q});
      check($sformatf("vec%0d_r", i), {16'd0, ro}, {16'd0, vecs[i].r});
      check($sformatf("vec%0d_dbz", i), {31'd0, dz}, {31'd0, vecs[i].dbz});
      check($sformatf("vec%0d_latency", i), lat, vecs[i].dbz ? 32'd1 : 32'd17);
      check($sformatf("vec%0d_busy_cycles", i), busy_n, vecs[i].dbz ? 32'd1 : 32'd17);
    end

    // Abort mid-calculation with reset, then a fresh request.
    @(negedge clk);
    x = 16'd100; y = 16'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    x = 16'd1; y = 16'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1; #1;
    check("abort_outputs_zero", {12'd0, q, r, busy, done, div_by_zero, 1'b0}, 32'd0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) got = 1'b1;
    end
    check("abort_no_done", {31'd0, got}, 32'd0);
    run(16'd9, 16'd3, qo, ro, dz, lat, busy_n);
    check("after_abort_q", {16'd0, qo}, 32'd3);
    check("after_abort_r", {16'd0, ro}, 32'd0);
    check("after_abort_latency", lat, 32'd17);

    // Back-to-back with start held high.
    @(negedge clk);
    x = 16'd50; y = 16'd5; start = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (done) got = 1'b1;
    end
    check("b2b_first_done", {31'd0, got}, 32'd1);
    check("b2b_first_q", {16'd0, q}, 32'd10);
    check("b2b_first_r", {16'd0, r}, 32'd0);
    x = 16'd7; y = 16'd9;
    got = 1'b0; gap = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      gap++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check("b2b_second_gap", gap, 32'd18);
    check("b2b_second_q", {16'd0, q}, 32'd0);
    check("b2b_second_r", {16'd0, r}, 32'd7);
    @(posedge clk); #1;
    check("b2b_idle_after", {30'd0, busy, done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
